// File: rtl/traffic_pkg.sv
// Shared phase, lamp and direction definitions for the intersection phase scheduler.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Packed lamp word {w,s,e,n}: only the granted approach may leave red.
  function automatic logic [11:0] lamp_vec(input phase_t ph, input logic [1:0] dir);
    logic [11:0] v;
    for (int k = 0; k < 4; k++) begin
      v[3*k +: 3] = LAMP_RED;
      if (dir == 2'(k)) begin
        if (ph == GREEN)       v[3*k +: 3] = LAMP_GRN;
        else if (ph == YELLOW) v[3*k +: 3] = LAMP_YEL;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority encoder: first set bit of pending searching last+1, last+2, ... modulo 4.
module rr_pick4 (
  input  logic [3:0] pending,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] cand;

  // Scan farthest to nearest so the nearest requester after last wins.
  always_comb begin
    idx   = last;
    found = |pending;
    cand  = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (pending[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Demand-driven four-way phase scheduler: round-robin green grants bounded by
// min/max green, fixed yellow, all-red clearance, and emergency preempt.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN  = 20,
  parameter int unsigned GREEN_MAX  = 60,
  parameter int unsigned YELLOW_CYC = 5,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned TIMER_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       preempt_vld,
  input  logic [1:0] preempt_dir,
  output logic [2:0] n_lights,
  output logic [2:0] e_lights,
  output logic [2:0] s_lights,
  output logic [2:0] w_lights,
  output logic [1:0] phase,
  output logic [1:0] cur_dir
);

  localparam logic [TIMER_W-1:0] AR_TERM   = TIMER_W'(ALLRED_CYC - 1);
  localparam logic [TIMER_W-1:0] GMIN_TERM = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_TERM = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] Y_TERM    = TIMER_W'(YELLOW_CYC - 1);

  phase_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   term_c;
  logic [3:0]           pending;
  logic [3:0]           dir_mask_c;
  logic [3:0]           green_mask_c;
  logic [3:0]           others_c;
  logic [1:0]           pick_idx;
  logic                 pick_found;
  logic                 to_green_c;
  logic                 to_yellow_c;
  logic                 to_allred_c;
  logic [1:0]           green_dir_c;

  rr_pick4 u_pick (
    .pending (pending),
    .last    (cur_dir),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign dir_mask_c   = 4'b0001 << cur_dir;
  assign others_c     = pending & ~dir_mask_c;
  assign green_mask_c = (state == GREEN) ? dir_mask_c : 4'b0000;

  // Transition conditions and per-state timer terminal count.
  always_comb begin
    term_c      = AR_TERM;
    to_green_c  = 1'b0;
    to_yellow_c = 1'b0;
    to_allred_c = 1'b0;
    green_dir_c = pick_idx;
    case (state)
      ALL_RED: begin
        term_c = AR_TERM;
        if (timer >= AR_TERM) begin
          if (preempt_vld) begin
            to_green_c  = 1'b1;
            green_dir_c = preempt_dir;
          end else if (pick_found) begin
            to_green_c = 1'b1;
          end
        end
      end
      GREEN: begin
        term_c = GMAX_TERM;
        if (preempt_vld) to_yellow_c = (preempt_dir != cur_dir);
        else             to_yellow_c = (timer >= GMIN_TERM) && (|others_c) &&
                                       (!req[cur_dir] || (timer >= GMAX_TERM));
      end
      YELLOW: begin
        term_c      = Y_TERM;
        to_allred_c = (timer == Y_TERM);
      end
      default: ;
    endcase
  end

  // Phase FSM with registered lamps, phase and grant direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ALL_RED;
      phase    <= ALL_RED;
      timer    <= '0;
      pending  <= 4'b0000;
      cur_dir  <= DIR_W;
      {w_lights, s_lights, e_lights, n_lights} <= {4{LAMP_RED}};
    end else begin
      pending <= (pending | req) & ~green_mask_c;
      timer   <= (timer < term_c) ? timer + TIMER_W'(1) : timer;
      if (to_green_c) begin
        state   <= GREEN;
        phase   <= GREEN;
        timer   <= '0;
        cur_dir <= green_dir_c;
        {w_lights, s_lights, e_lights, n_lights} <= lamp_vec(GREEN, green_dir_c);
      end else if (to_yellow_c) begin
        state <= YELLOW;
        phase <= YELLOW;
        timer <= '0;
        {w_lights, s_lights, e_lights, n_lights} <= lamp_vec(YELLOW, cur_dir);
      end else if (to_allred_c) begin
        state <= ALL_RED;
        phase <= ALL_RED;
        timer <= '0;
        {w_lights, s_lights, e_lights, n_lights} <= {4{LAMP_RED}};
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for traffic_phase_sched: directed scenarios plus randomized traffic
// against a rule-level reference model of the intersection.
module tb_traffic_phase_sched;

  localparam int GMIN = 20;
  localparam int GMAX = 60;
  localparam int YC   = 5;
  localparam int AR   = 2;
  localparam logic [11:0] ALLRED_L = 12'b100100100100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       pv = 1'b0;
  logic [1:0] pdir = 2'd0;
  logic [2:0] n_lights, e_lights, s_lights, w_lights;
  logic [1:0] phase, cur_dir;
  logic [11:0] lamps;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_phase_sched #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_CYC(YC), .ALLRED_CYC(AR), .TIMER_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .preempt_vld(pv), .preempt_dir(pdir),
    .n_lights(n_lights), .e_lights(e_lights), .s_lights(s_lights), .w_lights(w_lights),
    .phase(phase), .cur_dir(cur_dir)
  );

  assign lamps = {w_lights, s_lights, e_lights, n_lights};

  always #5 clk = ~clk;

  // Reference model: 0=all-red, 1=green, 2=yellow; time-in-phase is unbounded.
  int       m_st = 0;
  int       m_tm = 0;
  int       m_dir = 3;
  bit [3:0] m_pend = 4'b0000;

  always @(posedge clk) begin : model
    int       nst, ndir;
    bit       others;
    bit [3:0] np;
    if (rst) begin
      m_st = 0; m_tm = 0; m_dir = 3; m_pend = 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++)
        np[k] = (m_pend[k] | req[k]) & !(m_st == 1 && m_dir == k);
      nst = m_st; ndir = m_dir;
      others = 1'b0;
      for (int k = 0; k < 4; k++) if (k != m_dir && m_pend[k]) others = 1'b1;
      if (m_st == 0) begin
        if (m_tm >= AR - 1) begin
          if (pv) begin
            nst = 1; ndir = int'(pdir);
          end else begin
            for (int s = 1; s <= 4; s++)
              if (nst == 0 && m_pend[(m_dir + s) % 4]) begin
                nst = 1; ndir = (m_dir + s) % 4;
              end
          end
        end
      end else if (m_st == 1) begin
        if (pv) begin
          if (int'(pdir) != m_dir) nst = 2;
        end else if (m_tm >= GMIN - 1 && others && (!req[m_dir] || m_tm >= GMAX - 1)) begin
          nst = 2;
        end
      end else begin
        if (m_tm >= YC - 1) nst = 0;
      end
      m_tm   = (nst != m_st) ? 0 : m_tm + 1;
      m_st   = nst;
      m_dir  = ndir;
      m_pend = np;
    end
  end

  function automatic logic [2:0] exp_lamp(input int k);
    if (m_st == 0 || m_dir != k) return 3'b100;
    return (m_st == 1) ? 3'b001 : 3'b010;
  endfunction

  function automatic int non_red_count(input logic [11:0] l);
    int c = 0;
    for (int k = 0; k < 4; k++) if (l[3*k +: 3] !== 3'b100) c++;
    return c;
  endfunction

  // Holds reset across two edges, leaves rst low at a falling edge.
  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; pv = 1'b0; pdir = 2'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; pv = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (lamps !== ALLRED_L) begin n_bad++; $display("FAIL reset_lamps: got %b want %b", lamps, ALLRED_L); end
    n_cmp++;
    if (phase !== 2'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_cmp++;
    if (cur_dir !== 2'd3) begin n_bad++; $display("FAIL reset_cur_dir: got %0d want 3", cur_dir); end
    rst = 1'b0;
  endtask

  task automatic test_idle_first_grant();
    int bad = 0;
    do_reset();
    repeat (50) begin
      @(negedge clk);
      if (lamps !== ALLRED_L || phase !== 2'd0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL idle_all_red: %0d bad cycles, want 0", bad); end
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (n_lights !== 3'b100) begin n_bad++; $display("FAIL first_grant_edge1: n=%b want 100", n_lights); end
    @(negedge clk);
    n_cmp++;
    if (n_lights !== 3'b001 || phase !== 2'd1 || cur_dir !== 2'd0) begin
      n_bad++; $display("FAIL first_grant_edge2: n=%b phase=%0d dir=%0d want 001/1/0", n_lights, phase, cur_dir);
    end
  endtask

  task automatic test_min_max_green();
    int w, g, y, a;
    do_reset();
    req = 4'b0001;
    w = 0;
    while (n_lights !== 3'b001 && w < 20) begin @(negedge clk); w++; end
    req = 4'b0011;
    @(negedge clk);
    req = 4'b0001;
    g = 1;
    while (n_lights === 3'b001 && g < 200) begin g++; @(negedge clk); end
    n_cmp++;
    if (g != GMAX) begin n_bad++; $display("FAIL max_green_len: got %0d want %0d", g, GMAX); end
    y = 0;
    while (n_lights === 3'b010 && y < 50) begin y++; @(negedge clk); end
    n_cmp++;
    if (y != YC) begin n_bad++; $display("FAIL yellow_len: got %0d want %0d", y, YC); end
    a = 0;
    while (lamps === ALLRED_L && a < 50) begin a++; @(negedge clk); end
    n_cmp++;
    if (a != AR) begin n_bad++; $display("FAIL allred_len: got %0d want %0d", a, AR); end
    n_cmp++;
    if (e_lights !== 3'b001) begin n_bad++; $display("FAIL next_grant_e: e=%b want 001", e_lights); end

    do_reset();
    req = 4'b0001;
    w = 0;
    while (n_lights !== 3'b001 && w < 20) begin @(negedge clk); w++; end
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    g = 1;
    while (n_lights === 3'b001 && g < 200) begin g++; @(negedge clk); end
    n_cmp++;
    if (g != GMIN) begin n_bad++; $display("FAIL min_green_len: got %0d want %0d", g, GMIN); end
  endtask

  task automatic test_round_robin();
    int w, prev, viol;
    int order[$];
    do_reset();
    req = 4'b0010;
    w = 0;
    while (e_lights !== 3'b001 && w < 20) begin @(negedge clk); w++; end
    order.push_back(1);
    prev = 1;
    viol = 0;
    req = 4'b1001;
    @(negedge clk);
    req = 4'b0000;
    repeat (300) begin
      if (non_red_count(lamps) > 1) viol++;
      for (int k = 0; k < 4; k++)
        if (lamps[3*k +: 3] === 3'b001 && k != prev) begin order.push_back(k); prev = k; end
      @(negedge clk);
    end
    n_cmp++;
    if (order.size() != 3 || order[0] != 1 || order[1] != 3 || order[2] != 0) begin
      n_bad++; $display("FAIL rr_order: got size %0d seq %p want 1,3,0", order.size(), order);
    end
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL rr_one_non_red: %0d violations want 0", viol); end
    n_cmp++;
    if (cur_dir !== 2'd0 || n_lights !== 3'b001) begin
      n_bad++; $display("FAIL rr_rest_n: dir=%0d n=%b want 0/001", cur_dir, n_lights);
    end
  endtask

  task automatic test_rest_green();
    int w, bad;
    do_reset();
    req = 4'b0001;
    w = 0;
    while (n_lights !== 3'b001 && w < 20) begin @(negedge clk); w++; end
    bad = 0;
    repeat (520) begin
      @(negedge clk);
      if (n_lights !== 3'b001) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL rest_green: %0d non-green cycles want 0", bad); end
    req = 4'b0011;
    @(negedge clk);
    req = 4'b0001;
    n_cmp++;
    if (n_lights !== 3'b001) begin n_bad++; $display("FAIL rest_latch: n=%b want 001", n_lights); end
    @(negedge clk);
    n_cmp++;
    if (n_lights !== 3'b010) begin n_bad++; $display("FAIL rest_saturated_exit: n=%b want 010", n_lights); end
  endtask

  task automatic test_preempt();
    int w, y, a, bad;
    do_reset();
    req = 4'b0001;
    w = 0;
    while (n_lights !== 3'b001 && w < 20) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    pv = 1'b1; pdir = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (n_lights !== 3'b010 || phase !== 2'd2) begin
      n_bad++; $display("FAIL preempt_yellow_now: n=%b phase=%0d want 010/2", n_lights, phase);
    end
    y = 0;
    while (n_lights === 3'b010 && y < 50) begin y++; @(negedge clk); end
    n_cmp++;
    if (y != YC) begin n_bad++; $display("FAIL preempt_yellow_len: got %0d want %0d", y, YC); end
    a = 0;
    while (lamps === ALLRED_L && a < 50) begin a++; @(negedge clk); end
    n_cmp++;
    if (a != AR) begin n_bad++; $display("FAIL preempt_allred_len: got %0d want %0d", a, AR); end
    n_cmp++;
    if (s_lights !== 3'b001 || cur_dir !== 2'd2) begin
      n_bad++; $display("FAIL preempt_grant_s: s=%b dir=%0d want 001/2", s_lights, cur_dir);
    end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (s_lights !== 3'b001 || n_lights !== 3'b100) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL preempt_hold: %0d bad cycles want 0", bad); end
    pv = 1'b0;
    w = 0;
    while (n_lights !== 3'b001 && w < 60) begin @(negedge clk); w++; end
    n_cmp++;
    if (n_lights !== 3'b001 || cur_dir !== 2'd0) begin
      n_bad++; $display("FAIL preempt_release: n=%b dir=%0d want 001/0", n_lights, cur_dir);
    end
  endtask

  task automatic test_reset_mid_yellow();
    int w, bad;
    do_reset();
    req = 4'b0010;
    w = 0;
    while (e_lights !== 3'b001 && w < 20) begin @(negedge clk); w++; end
    req = 4'b0001;
    w = 0;
    while (e_lights !== 3'b010 && w < 60) begin @(negedge clk); w++; end
    n_cmp++;
    if (e_lights !== 3'b010) begin n_bad++; $display("FAIL mid_yellow_reach: e=%b want 010", e_lights); end
    rst = 1'b1; req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (lamps !== ALLRED_L || phase !== 2'd0 || cur_dir !== 2'd3) begin
      n_bad++; $display("FAIL mid_yellow_reset: lamps=%b phase=%0d dir=%0d want %b/0/3", lamps, phase, cur_dir, ALLRED_L);
    end
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (lamps !== ALLRED_L) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL pending_cleared: %0d non-red cycles want 0", bad); end
    req = 4'b0001;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (n_lights !== 3'b001) begin n_bad++; $display("FAIL regrant_after_reset: n=%b want 001", n_lights); end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    do_reset();
    repeat (4000) begin
      @(negedge clk);
      exp = {exp_lamp(3), exp_lamp(2), exp_lamp(1), exp_lamp(0)};
      n_cmp++;
      if (lamps !== exp || phase !== 2'(m_st) || cur_dir !== 2'(m_dir)) begin
        n_bad++;
        $display("FAIL random_model t=%0t: lamps=%b phase=%0d dir=%0d want %b/%0d/%0d",
                 $time, lamps, phase, cur_dir, exp, m_st, m_dir);
      end
      n_cmp++;
      if (non_red_count(lamps) > 1) begin
        n_bad++; $display("FAIL random_one_non_red t=%0t: lamps=%b", $time, lamps);
      end
      if ($urandom_range(0, 19) == 0) req = 4'($urandom);
      if ($urandom_range(0, 149) == 0) pv = ~pv;
      if ($urandom_range(0, 39) == 0) pdir = 2'($urandom);
      rst = ($urandom_range(0, 1499) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_first_grant();
    test_min_max_green();
    test_round_robin();
    test_rest_green();
    test_preempt();
    test_reset_mid_yellow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sched.md
Name: traffic_phase_sched

Overview:
- Demand-driven phase scheduler for the four-way intersection, owning the n/s/e/w 3-bit lamp outputs.
- Latches vehicle-sensor requests per approach and grants green round-robin among requesting approaches.
- Green time is bounded by a minimum and a maximum. Every green is followed by a yellow interval and then an all-red clearance.
- An emergency preempt input forces the intersection to a chosen approach.

Parameters:
- GREEN_MIN, 20, minimum green cycles once granted
- GREEN_MAX, 60, maximum green cycles while other approaches wait
- YELLOW_CYC, 5, yellow cycles
- ALLRED_CYC, 2, all-red clearance cycles before the next grant
- TIMER_W, 8, phase timer width
- Legal ranges: 1<=GREEN_MIN<=GREEN_MAX<2^TIMER_W; YELLOW_CYC>=1; ALLRED_CYC>=1

Ports:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  vehicle sensors, level; bit0=N, 1=E, 2=S, 3=W
- preempt_vld  in  1  emergency preempt active
- preempt_dir  in  2  preempt approach (0=N, 1=E, 2=S, 3=W)
- n_lights  out  3  lamp for N; {red,yellow,green}
- e_lights  out  3  lamp for E
- s_lights  out  3  lamp for S
- w_lights  out  3  lamp for W
- phase  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW
- cur_dir  out  2  approach currently or last granted

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=ALL_RED, timer=0, pending=4'b0000, cur_dir=3 (so the first search starts at N).
  - All four lights=3'b100; phase=0.
- All outputs are registered and update on the same edge as the state register.
- Lamp encoding: granted approach shows 3'b001 in GREEN and 3'b010 in YELLOW. Every other approach, and all approaches in ALL_RED, show 3'b100. At most one approach is ever non-red.
- Pending update: pending[k] <= pending[k] | req[k] each cycle. pending[k] is forced to 0 while state==GREEN and cur_dir==k.
- Timer: reset to 0 on every state change, otherwise incremented. It saturates at the current state's terminal count.
- ALL_RED transitions, when timer>=ALLRED_CYC-1:
  - preempt_vld=1: go to GREEN with cur_dir=preempt_dir.
  - else if pending!=0: go to GREEN with cur_dir = first set pending bit searching cur_dir+1, cur_dir+2, … modulo 4.
  - else stay in ALL_RED (idle).
- GREEN transitions:
  - preempt_vld=1 and preempt_dir!=cur_dir: go to YELLOW immediately, ignoring GREEN_MIN.
  - preempt_vld=1 and preempt_dir==cur_dir: hold GREEN.
  - otherwise go to YELLOW when timer>=GREEN_MIN-1, and others_pending!=0, and (req[cur_dir]==0 or timer>=GREEN_MAX-1). others_pending is pending with the cur_dir bit masked.
  - With no other demand, green rests indefinitely.
- YELLOW: go to ALL_RED when timer==YELLOW_CYC-1. Preempt never shortens yellow.
- Simultaneous events:
  - A req on the current green approach is not latched during GREEN; it is re-latched after green ends if still held.
  - Preempt takes priority over round-robin in ALL_RED. cur_dir then becomes preempt_dir, and later round-robin continues from it.
  - preempt_dir changing mid-preempt is handled like a new preempt.
- Reset mid-operation (any state): all outputs return to reset values on the next edge. Yellow and all-red are not completed.
- Phase durations (cycles): GREEN in [GREEN_MIN, GREEN_MAX] when contested, YELLOW = YELLOW_CYC, ALL_RED >= ALLRED_CYC.

Decomposition:
- Package traffic_pkg holds:
  - phase enum (ALL_RED, GREEN, YELLOW);
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001;
  - direction constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3.
- One sub-module, rr_pick4: combinational rotating-priority encoder. Inputs are a 4-bit pending vector and a 2-bit last grant; outputs are a 2-bit index and found.
- Timer and FSM stay in the top module.

Test Plan:
- Idle and first grant: reset, req=0 for 50 cycles, so all lights stay 3'b100 and phase=0. Then hold req[0]=1 from rst release: n_lights=3'b001 from the 2nd edge after release.
- Min/max green (defaults): N green with req[0] held and req[1] pulsed once → N green exactly 60 cycles, then 5 yellow (3'b010), then 2 all-red, then e_lights=3'b001. Repeat with req[0] dropped at green start → N green exactly 20 cycles.
- Round-robin: cur_dir=E green, then pulse req=4'b1001 (N and W) → order W then N. Each is granted once; the rule that at most one approach is non-red holds on every cycle.
- Rest in green: only N requested, no other req for 500 cycles → n_lights stays 3'b001 and the timer saturates without wrap.
- Preempt: N green at timer=3, assert preempt_vld with preempt_dir=2 → yellow starts next edge, lasts 5 cycles, then 2 all-red, then s_lights=3'b001. S holds green while preempt_vld=1 even with req[0] pending.
- Reset mid-yellow: assert rst during E yellow → next edge all lights 3'b100, phase=0, pending=0. Previously pending requests are lost until re-asserted.
